// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared geometry, FSM encoding and word-merge helper for the L1 data cache
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int NUM_LINES  = 16;
    localparam int LINE_BYTES = 32;
    localparam int LINE_W     = 8 * LINE_BYTES;
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int OFFS_W     = $clog2(LINE_BYTES);
    localparam int TAG_W      = ADDR_W - IDX_W - OFFS_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        FILL_DONE = 2'd3
    } state_t;

    function automatic logic [LINE_W-1:0] merge_word(
        input logic [LINE_W-1:0] line,
        input logic [2:0]        sel,
        input logic [31:0]       word
    );
        logic [LINE_W-1:0] merged;
        merged = line;
        merged[{sel, 5'b0} +: 32] = word;
        return merged;
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - tag/valid/dirty/data arrays with async read and sync write
module dcache_sram import dcache_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              wr_dirty
);

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [LINE_W-1:0]    lines [NUM_LINES];

    // Only the status bits are cleared; tag/data contents are don't-care while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
            dirty[wr_idx] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx]  <= wr_tag;
            lines[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = lines[rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate L1 data cache controller
module dcache_controller import dcache_pkg::*; (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    state_t            state, state_nxt;
    logic [LINE_W-1:0] fill_buf;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        word_sel;
    logic              req, hit;
    logic              line_valid, line_dirty;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_data;

    logic              we, wr_dirty;
    logic [LINE_W-1:0] wr_data;
    logic              unused_addr_bits;

    assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign idx              = cpu_addr_i[OFFS_W +: IDX_W];
    assign word_sel         = cpu_addr_i[OFFS_W-1:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit         = req && line_valid && (line_tag == req_tag);
    assign cpu_stall_o = req && !hit;
    assign cpu_data_o  = (hit && cpu_MemRead_i) ? line_data[{word_sel, 5'b0} +: 32] : 32'd0;

    dcache_sram u_sram (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .rd_idx   (idx),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .we       (we),
        .wr_idx   (idx),
        .wr_tag   (req_tag),
        .wr_data  (wr_data),
        .wr_dirty (wr_dirty)
    );

    // A store that missed merges on the hit cycle after FILL_DONE, so the fill itself is clean.
    always_comb begin
        we       = 1'b0;
        wr_dirty = 1'b0;
        wr_data  = fill_buf;
        if (state == FILL_DONE) begin
            we = 1'b1;
        end else if (hit && cpu_MemWrite_i) begin
            we       = 1'b1;
            wr_dirty = 1'b1;
            wr_data  = merge_word(line_data, word_sel, cpu_data_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            fill_buf <= '0;
        end else begin
            state <= state_nxt;
            if (state == FILL && mem_ack_i) begin
                fill_buf <= mem_data_i;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    state_nxt = (line_valid && line_dirty) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {line_tag, idx, {OFFS_W{1'b0}}};
                mem_data_o   = line_data;
                if (mem_ack_i) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, idx, {OFFS_W{1'b0}}};
                if (mem_ack_i) begin
                    state_nxt = FILL_DONE;
                end
            end
            FILL_DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
